// File: rtl/lin_rec_gen_if.sv
// Control and dual-rail link bundle for lin_rec_gen: start/seed/count and the
// asynchronous acknowledge flow into the generator; tokens and status flow out.
interface lin_rec_gen_if #(
    parameter int WIDTH = 32,
    parameter int ORDER = 2
);
    localparam int RAIL_NUM = 2;

    logic                           start;
    logic [ORDER-1:0][WIDTH-1:0]    seed;
    logic [15:0]                    count;
    logic                           ack_i;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out;
    logic                           busy;
    logic                           done;
    logic                           ovf;

    modport master (output start, seed, count, ack_i, input  out, busy, done, ovf);
    modport slave  (input  start, seed, count, ack_i, output out, busy, done, ovf);
endinterface

// File: rtl/lin_rec_gen.sv
// Clocked linear-recurrence generator emitting each term as a dual-rail token
// (ENC "TP" two-phase, "FP" four-phase). Optional macro LIN_REC_SAT_EN saturates overflowing sums.
module lin_rec_gen #(
    parameter     ENC   = "TP",
    parameter int WIDTH = 32,
    parameter int ORDER = 2
) (
    input  logic         clk,
    input  logic         rst,
    lin_rec_gen_if.slave bus
);
    localparam int          RAIL_NUM = 2;
    localparam bit          IS_FP    = (ENC == "FP");
    localparam logic [15:0] ORDER_W  = 16'(ORDER);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EMIT = 3'd1,
        S_WAIT = 3'd2,
        S_RTZ  = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    state_t                         state_r, state_s;
    logic                           ack_meta_r, ack_s_r;
    logic                           par_r, par_s;
    logic [ORDER-1:0][WIDTH-1:0]    h_r, h_s;
    logic [15:0]                    cnt_r, cnt_s, cnt_inc_s;
    logic                           gen_r, gen_s;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out_r, out_s;
    logic                           busy_r, busy_s;
    logic                           done_r, done_s;
    logic                           ovf_r, ovf_s;
    logic [WIDTH+1:0]               sum_s;
    logic                           sum_ovf_s;
    logic [WIDTH-1:0]               term_s;

    // Rail pair for one bit: rail[1] carries logic 1, rail[0] carries logic 0.
    function automatic logic [RAIL_NUM-1:0] rail_code(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // Sum of the whole history; two guard bits cover up to four WIDTH-bit terms.
    function automatic logic [WIDTH+1:0] hist_sum(input logic [ORDER-1:0][WIDTH-1:0] h);
        logic [WIDTH+1:0] acc;
        acc = '0;
        for (int j = 0; j < ORDER; j++) begin
            acc = acc + {2'b00, h[j]};
        end
        return acc;
    endfunction

    // Next term candidate and its overflow flag
    always_comb begin
        sum_s     = hist_sum(h_r);
        sum_ovf_s = |sum_s[WIDTH+1:WIDTH];
`ifdef LIN_REC_SAT_EN
        if (sum_ovf_s) begin
            term_s = '1;
        end else begin
            term_s = sum_s[WIDTH-1:0];
        end
`else
        term_s = sum_s[WIDTH-1:0];
`endif
    end

    // Next-state and datapath update for the token FSM
    always_comb begin
        state_s   = state_r;
        par_s     = par_r;
        h_s       = h_r;
        cnt_s     = cnt_r;
        gen_s     = gen_r;
        out_s     = out_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        ovf_s     = ovf_r;
        cnt_inc_s = cnt_r + 16'd1;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    h_s     = bus.seed;
                    cnt_s   = 16'd0;
                    gen_s   = 1'b0;
                    ovf_s   = 1'b0;
                    busy_s  = 1'b1;
                    state_s = S_EMIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_EMIT: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (IS_FP) begin
                        out_s[i] = rail_code(h_r[0][i]);
                    end else begin
                        out_s[i] = out_r[i] ^ rail_code(h_r[0][i]);
                    end
                end
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (IS_FP) begin
                    if (ack_s_r) begin
                        out_s   = '0;
                        state_s = S_RTZ;
                    end else begin
                        state_s = S_WAIT;
                    end
                end else begin
                    if (ack_s_r != par_r) begin
                        par_s   = ~par_r;
                        state_s = S_NEXT;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
            end
            S_RTZ: begin
                if (!ack_s_r) begin
                    state_s = S_NEXT;
                end else begin
                    state_s = S_RTZ;
                end
            end
            S_NEXT: begin
                cnt_s = cnt_inc_s;
                if ((bus.count != 16'd0) && (cnt_inc_s == bus.count)) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    // h[0] is the head; the rest rotate so the window always
                    // holds the last ORDER terms (seeds included) in some order.
                    for (int j = 1; j < ORDER - 1; j++) begin
                        h_s[j] = h_r[j+1];
                    end
                    h_s[ORDER-1] = h_r[0];
                    if (!gen_r && (cnt_inc_s < ORDER_W)) begin
                        h_s[0] = h_r[1];
                    end else begin
                        gen_s  = 1'b1;
                        h_s[0] = term_s;
                        ovf_s  = ovf_r | sum_ovf_s;
                    end
                    state_s = S_EMIT;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // Two-flop synchronizer for the link acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta_r <= 1'b0;
            ack_s_r    <= 1'b0;
        end else begin
            ack_meta_r <= bus.ack_i;
            ack_s_r    <= ack_meta_r;
        end
    end

    // FSM state, history, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            par_r   <= 1'b0;
            h_r     <= '0;
            cnt_r   <= 16'd0;
            gen_r   <= 1'b0;
            out_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            par_r   <= par_s;
            h_r     <= h_s;
            cnt_r   <= cnt_s;
            gen_r   <= gen_s;
            out_r   <= out_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ovf_r   <= ovf_s;
        end
    end

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_lin_rec_gen.sv
// Self-checking bench for lin_rec_gen: two four-phase instances (order 2 and 3)
// and one two-phase instance, compared against a plain-arithmetic recurrence model.
module tb_lin_rec_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lin_rec_gen_if #(.WIDTH(8), .ORDER(2)) ia ();
    lin_rec_gen_if #(.WIDTH(8), .ORDER(3)) ib ();
    lin_rec_gen_if #(.WIDTH(4), .ORDER(2)) ic ();

    lin_rec_gen #(.ENC("FP"), .WIDTH(8), .ORDER(2)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
    lin_rec_gen #(.ENC("FP"), .WIDTH(8), .ORDER(3)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
    lin_rec_gen #(.ENC("TP"), .WIDTH(4), .ORDER(2)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_done;
    logic [63:0] exp_q[$];
    logic        exp_ovf;
    logic [7:0]  got_q[$];
    logic [7:0]  c_prev;
    logic [3:0]  x1, x0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: t[k] = seed[k] for k < order, else sum of previous order terms.
    task automatic model(input int order, input int width, input logic [63:0] s0,
                         input logic [63:0] s1, input logic [63:0] s2, input int n);
        logic [63:0] sd[3];
        logic [63:0] maxv, sum;
        sd[0] = s0; sd[1] = s1; sd[2] = s2;
        maxv = (64'd1 << width) - 64'd1;
        exp_q = {};
        exp_ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k < order) begin
                exp_q.push_back(sd[k]);
            end else begin
                sum = 64'd0;
                for (int j = 1; j <= order; j++) sum = sum + exp_q[k-j];
                if (sum > maxv) begin
                    exp_ovf = 1'b1;
`ifdef LIN_REC_SAT_EN
                    sum = maxv;
`else
                    sum = sum & maxv;
`endif
                end
                exp_q.push_back(sum);
            end
        end
    endtask

    task automatic compare_terms(input string tag);
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_t%0d", tag, k), 64'(got_q[k]), exp_q[k]);
    endtask

    task automatic end_checks(input string tag, input logic ovf, input logic busy);
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({tag, "_done"}, 64'(n_done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic set_ack(input int sel, input logic v);
        if (sel == 0) ia.ack_i = v;
        else          ib.ack_i = v;
    endtask

    // Four-phase receiver for instance a (sel 0) or b (sel 1).
    task automatic run_fp(input int sel, input bit do_start, input int stop_at);
        logic [15:0] cw;
        logic [7:0]  v;
        logic        ok, ack_now, busy_now, done_now;
        bit          fin;
        int          guard, dly;
        fin = 1'b0;
        guard = 0;
        if (do_start) begin
            if (sel == 0) ia.start = 1'b1;
            else          ib.start = 1'b1;
            @(negedge clk);
            ia.start = 1'b0;
            ib.start = 1'b0;
        end
        while (!fin && guard < 3000) begin
            @(negedge clk);
            guard++;
            cw       = (sel == 0) ? ia.out   : ib.out;
            ack_now  = (sel == 0) ? ia.ack_i : ib.ack_i;
            busy_now = (sel == 0) ? ia.busy  : ib.busy;
            done_now = (sel == 0) ? ia.done  : ib.done;
            if (done_now) n_done++;
            if (!ack_now && cw != 16'd0) begin
                ok = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (cw[2*i +: 2] != 2'b01 && cw[2*i +: 2] != 2'b10) ok = 1'b0;
                    v[i] = cw[2*i+1];
                end
                chk("fp_codeword", 64'(ok), 64'd1);
                got_q.push_back(v);
                if (stop_at != 0 && got_q.size() == stop_at) begin
                    fin = 1'b1;
                end else begin
                    dly = int'($urandom_range(0, 3));
                    repeat (dly) @(negedge clk);
                    guard += dly;
                    set_ack(sel, 1'b1);
                end
            end else if (ack_now && cw == 16'd0) begin
                set_ack(sel, 1'b0);
            end else if (!ack_now && !busy_now) begin
                fin = 1'b1;
            end
        end
        chk("fp_run_bound", 64'(fin), 64'd1);
        if (stop_at == 0) begin
            repeat (4) begin
                @(negedge clk);
                if ((sel == 0) ? ia.done : ib.done) n_done++;
            end
        end
    endtask

    // Two-phase receiver for instance c; a token is any change of rail state.
    task automatic run_tp(input bit poke);
        logic [7:0] cw, df;
        logic [7:0] v;
        logic       ok;
        bit         fin;
        int         guard, dly;
        fin = 1'b0;
        guard = 0;
        ic.start = 1'b1;
        @(negedge clk);
        ic.start = 1'b0;
        while (!fin && guard < 3000) begin
            @(negedge clk);
            guard++;
            cw = ic.out;
            if (ic.done) n_done++;
            if (cw != c_prev) begin
                df = cw ^ c_prev;
                ok = 1'b1;
                v  = 8'd0;
                for (int i = 0; i < 4; i++) begin
                    if (df[2*i +: 2] != 2'b01 && df[2*i +: 2] != 2'b10) ok = 1'b0;
                    v[i] = df[2*i+1];
                end
                chk("tp_one_rail", 64'(ok), 64'd1);
                got_q.push_back(v);
                c_prev = cw;
                if (poke && got_q.size() == 2) begin
                    ic.seed  = {4'd9, 4'd9};
                    ic.start = 1'b1;
                    @(negedge clk);
                    ic.start = 1'b0;
                    guard++;
                end
                dly = int'($urandom_range(0, 3));
                repeat (dly) @(negedge clk);
                guard += dly;
                ic.ack_i = ~ic.ack_i;
            end else if (!ic.busy) begin
                fin = 1'b1;
            end
        end
        chk("tp_run_bound", 64'(fin), 64'd1);
        repeat (4) begin
            @(negedge clk);
            if (ic.done) n_done++;
        end
    endtask

    task automatic tp_rails_check(input string tag);
        logic [7:0] er;
        logic [3:0] t;
        for (int k = 0; k < exp_q.size(); k++) begin
            t  = exp_q[k][3:0];
            x1 = x1 ^ t;
            x0 = x0 ^ ~t;
        end
        for (int i = 0; i < 4; i++) begin
            er[2*i+1] = x1[i];
            er[2*i]   = x0[i];
        end
        chk({tag, "_rails"}, 64'(ic.out), 64'(er));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cw0;
        logic        stable;
        int          lat;
        logic [63:0] r0, r1, r2;

        rst = 1'b0;
        ia.start = 1'b0; ia.seed = '0; ia.count = 16'd0; ia.ack_i = 1'b0;
        ib.start = 1'b0; ib.seed = '0; ib.count = 16'd0; ib.ack_i = 1'b0;
        ic.start = 1'b0; ic.seed = '0; ic.count = 16'd0; ic.ack_i = 1'b0;
        c_prev = 8'd0; x1 = 4'd0; x0 = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_out",  64'(ia.out),  64'd0);
        chk("rst_busy", 64'(ia.busy), 64'd0);
        chk("rst_done", 64'(ia.done), 64'd0);
        chk("rst_ovf",  64'(ia.ovf),  64'd0);
        chk("rst_tp_out", 64'(ic.out), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fibonacci, 13 terms, no overflow
        ia.seed = {8'd1, 8'd0}; ia.count = 16'd13;
        model(2, 8, 64'd0, 64'd1, 64'd0, 13);
        got_q = {}; n_done = 0;
        run_fp(0, 1'b1, 0);
        compare_terms("fib13");
        end_checks("fib13", ia.ovf, ia.busy);

        // Fibonacci, 15 terms: last one overflows
        ia.count = 16'd15;
        model(2, 8, 64'd0, 64'd1, 64'd0, 15);
        got_q = {}; n_done = 0;
        run_fp(0, 1'b1, 0);
        compare_terms("fib15");
        end_checks("fib15", ia.ovf, ia.busy);
        if (got_q.size() == 15) begin
            chk("fib15_t13_lit", 64'(got_q[13]), 64'd233);
`ifdef LIN_REC_SAT_EN
            chk("fib15_t14_lit", 64'(got_q[14]), 64'd255);
`else
            chk("fib15_t14_lit", 64'(got_q[14]), 64'd121);
`endif
        end else begin
            chk("fib15_size", 64'(got_q.size()), 64'd15);
        end

        // Receiver stalls: codeword must hold, then spacer follows the ack
        ia.seed = {8'h3C, 8'h5A}; ia.count = 16'd3;
        model(2, 8, 64'h5A, 64'h3C, 64'd0, 3);
        got_q = {}; n_done = 0;
        run_fp(0, 1'b1, 1);
        cw0 = ia.out;
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ia.out != cw0 || !ia.busy) stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        chk("hold_busy", 64'(ia.busy), 64'd1);
        ia.ack_i = 1'b1;
        lat = 0;
        while (ia.out != 16'd0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("spacer_within_3", 64'(lat <= 3), 64'd1);
        run_fp(0, 1'b0, 0);
        compare_terms("hold");
        end_checks("hold", ia.ovf, ia.busy);

        // Random order-2 runs
        for (int r = 0; r < 4; r++) begin
            r0 = 64'($urandom_range(0, 255));
            r1 = 64'($urandom_range(0, 255));
            ia.seed = {r1[7:0], r0[7:0]};
            ia.count = 16'($urandom_range(1, 16));
            model(2, 8, r0, r1, 64'd0, int'(ia.count));
            got_q = {}; n_done = 0;
            run_fp(0, 1'b1, 0);
            compare_terms($sformatf("rnd_a%0d", r));
            end_checks($sformatf("rnd_a%0d", r), ia.ovf, ia.busy);
        end

        // Tribonacci 0,0,1 and random order-3 runs
        ib.seed = {8'd1, 8'd0, 8'd0}; ib.count = 16'd8;
        model(3, 8, 64'd0, 64'd0, 64'd1, 8);
        got_q = {}; n_done = 0;
        run_fp(1, 1'b1, 0);
        compare_terms("trib8");
        end_checks("trib8", ib.ovf, ib.busy);
        for (int r = 0; r < 3; r++) begin
            r0 = 64'($urandom_range(0, 255));
            r1 = 64'($urandom_range(0, 255));
            r2 = 64'($urandom_range(0, 255));
            ib.seed = {r2[7:0], r1[7:0], r0[7:0]};
            ib.count = 16'($urandom_range(1, 14));
            model(3, 8, r0, r1, r2, int'(ib.count));
            got_q = {}; n_done = 0;
            run_fp(1, 1'b1, 0);
            compare_terms($sformatf("rnd_b%0d", r));
            end_checks($sformatf("rnd_b%0d", r), ib.ovf, ib.busy);
        end

        // Two-phase link, seeds 2,3, with a stray start mid-run
        ic.seed = {4'd3, 4'd2}; ic.count = 16'd4;
        model(2, 4, 64'd2, 64'd3, 64'd0, 4);
        got_q = {}; n_done = 0;
        run_tp(1'b1);
        compare_terms("tp23");
        end_checks("tp23", ic.ovf, ic.busy);
        tp_rails_check("tp23");
        for (int r = 0; r < 3; r++) begin
            r0 = 64'($urandom_range(0, 15));
            r1 = 64'($urandom_range(0, 15));
            ic.seed = {r1[3:0], r0[3:0]};
            ic.count = 16'($urandom_range(1, 12));
            model(2, 4, r0, r1, 64'd0, int'(ic.count));
            got_q = {}; n_done = 0;
            run_tp(1'b0);
            compare_terms($sformatf("rnd_c%0d", r));
            end_checks($sformatf("rnd_c%0d", r), ic.ovf, ic.busy);
            tp_rails_check($sformatf("rnd_c%0d", r));
        end

        // Free-running with overflow, then reset while waiting for the 3rd ack
        ia.seed = {8'd100, 8'd200}; ia.count = 16'd0;
        model(2, 8, 64'd200, 64'd100, 64'd0, 3);
        got_q = {}; n_done = 0;
        run_fp(0, 1'b1, 3);
        compare_terms("free");
        chk("free_ovf", 64'(ia.ovf), 64'd1);
        chk("free_busy", 64'(ia.busy), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_out",  64'(ia.out),  64'd0);
        chk("async_rst_busy", 64'(ia.busy), 64'd0);
        chk("async_rst_ovf",  64'(ia.ovf),  64'd0);
        ia.ack_i = 1'b0; ib.ack_i = 1'b0; ic.ack_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Restart after reset begins again at seed[0]
        ia.seed = {8'd1, 8'd0}; ia.count = 16'd3;
        model(2, 8, 64'd0, 64'd1, 64'd0, 3);
        got_q = {}; n_done = 0;
        run_fp(0, 1'b1, 0);
        compare_terms("restart");
        end_checks("restart", ia.ovf, ia.busy);

        if (n_fail != 0) $display("comparisons not matching: %0d", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lin_rec_gen.md
# lin_rec_gen

Clocked linear-recurrence sequence generator: the parametrised successor to the self-timed Fibonacci loop. It produces up to `ORDER`-th order sums, e.g. Fibonacci, Lucas and Tribonacci, from programmable seeds, with a programmable term count and sticky overflow reporting. Each term is emitted as a dual-rail token on an asynchronous output link (`ENC` selects two-phase or four-phase). The block bridges the synchronous control domain to the dual-rail datapath.

## Interface
- `ENC`, "TP": link protocol. "TP" = two-phase transition signalling; "FP" = four-phase return-to-zero.
- `WIDTH`, 32: term width in bits, 4..64.
- `ORDER`, 2: recurrence order, 2..4. Each term is the sum of the previous `ORDER` terms.
- `RAIL_NUM`, 2 (localparam): rails per bit. Rail[1] = logic 1, rail[0] = logic 0.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `seed`  in  ORDER×WIDTH  initial terms, `seed[0]` emitted first; captured on accepted `start`.
- `count`  in  16  total terms to emit, seeds included; 0 = free-running.
- `ack_i`  in  1  link acknowledge, asynchronous to `clk`.
- `out`  out  WIDTH×RAIL_NUM  dual-rail link data.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse after the last term is acknowledged.
- `ovf`  out  1  sticky: some computed term exceeded 2^WIDTH−1.

## Operation
- `ack_i` passes through a 2-flop synchronizer (`ack_s`). All handshake decisions use `ack_s`.
- History: shift register `h[ORDER-1:0]` of WIDTH-bit terms, plus a 16-bit emitted-term counter.
- **IDLE**
  - `start` loads `h` from `seed`, clears the counter, clears `ovf`, sets `busy`, then goes to EMIT.
  - `start` while not IDLE is ignored.
- **EMIT** (one cycle)
  - The head term is driven as a token.
  - FP: rails go from all-zero to the codeword.
  - TP: for each bit, rail[value] toggles.
  - Goes to WAIT.
- **WAIT**
  - FP: waits for `ack_s`=1, then drives the spacer (all rails 0) and goes to RTZ.
  - TP: waits for `ack_s` ≠ the stored ack parity, then flips the parity and goes to NEXT.
- **RTZ** (FP only): waits for `ack_s`=0, then goes to NEXT.
- **NEXT**
  - Increments the counter.
  - If `count`≠0 and counter==`count`: pulse `done`, clear `busy`, go to IDLE.
  - Otherwise, while seeds remain, shift to the next seed.
  - Once the seeds are exhausted, compute sum = Σh over a (WIDTH+2)-bit adder and shift it in. Term = sum[WIDTH-1:0]; any set upper bit sets `ovf`.
  - Goes to EMIT.
- Free-running mode (`count`=0): the counter wraps at 16 bits and never terminates. Leaving it requires `rst`.
- Reset, at any time including mid-token:
  - `out`=all 0, `busy`=0, `done`=0, `ovf`=0.
  - Ack parity = 0, history = 0, state = IDLE.
  - In FP, a receiver holding ack high must release it; the block does not wait for it.
- TP rails are never all-zero-checked by the receiver. Rail state persists between tokens.

## Timing
- Accepted `start` at cycle 0 → first token on `out` at the end of cycle 1 (EMIT).
- Ack edge to synchronized recognition: 2–3 cycles.
- Per-term cycle count, assuming an immediate receiver:
  - FP: EMIT 1 + WAIT (sync) + RTZ (sync) + NEXT 1.
  - TP: EMIT 1 + WAIT (sync) + NEXT 1.
- Token data is held stable from EMIT until the acknowledge is seen. `out` never changes in two consecutive cycles within one token.
- `done` is asserted in the NEXT cycle of the final term. `busy` falls in the same cycle.

## Configuration
- `LIN_REC_SAT_EN`
  - Defined: an overflowing sum is replaced by 2^WIDTH−1, both in `out` and in the history. `ovf` is still set.
  - Undefined: terms wrap modulo 2^WIDTH.

## Test plan
- FP, WIDTH=8, ORDER=2, seeds 0,1, count=13 → tokens 0,1,1,2,3,5,8,13,21,34,55,89,144. `done` pulses once, `ovf`=0.
- Same, count=15 → 14th=233. 15th=121 with `ovf`=1; with `LIN_REC_SAT_EN`, 15th=255 with `ovf`=1.
- ORDER=3, seeds 0,0,1, count=8 → 0,0,1,1,2,4,7,13.
- FP, hold `ack_i`=0 for 100 cycles → codeword stable, no spacer, `busy`=1. Then raise `ack_i` → spacer within 3 cycles.
- TP, WIDTH=4, seeds 2,3, count=4 → per token exactly one rail toggles per bit. Final rail state matches XOR of emitted values 2,3,5,8. `start` pulsed mid-run is ignored.
- Assert `rst` low while in WAIT → `out`=0, `busy`=0, `ovf`=0 asynchronously. A new `start` after release restarts from `seed[0]`.
